// File: rtl/rename_alloc_ctrl_pkg.sv
// rtl/rename_alloc_ctrl_pkg.sv - shared sizes and free-port type for the rename allocator
package rename_alloc_ctrl_pkg;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PREG_W    = 6;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] reg_addr;
  } freeRegStruct;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } alloc_state_e;

endpackage

// File: rtl/rename_alloc_ctrl_prf_free_fifo.sv
// rtl/rename_alloc_ctrl_prf_free_fifo.sv - 2-read/2-write circular free list of physical tags
module prf_free_fifo
  import rename_alloc_ctrl_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = PREG_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic [1:0]                 i_pop_cnt,
  input  logic                       i_push_a,
  input  logic [W-1:0]               i_push_a_data,
  input  logic                       i_push_b,
  input  logic [W-1:0]               i_push_b_data,
  output logic [W-1:0]               o_rd_a,
  output logic [W-1:0]               o_rd_b,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_head_p1;
  logic [AW-1:0] w_tail_b;

  // Index arithmetic is modulo DEPTH by width, so 2-wide accesses wrap naturally.
  assign w_head_p1 = r_head + AW'(1);
  assign w_tail_b  = r_tail + AW'(i_push_a);
  assign o_rd_a    = r_mem[r_head];
  assign o_rd_b    = r_mem[w_head_p1];
  assign o_count   = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_pop_cnt != 2'd0) r_mem[r_head]    <= '0;
      if (i_pop_cnt == 2'd2) r_mem[w_head_p1] <= '0;
      if (i_push_a) r_mem[r_tail]   <= i_push_a_data;
      if (i_push_b) r_mem[w_tail_b] <= i_push_b_data;
      r_head  <= r_head + AW'(i_pop_cnt);
      r_tail  <= r_tail + AW'(i_push_a) + AW'(i_push_b);
      r_count <= r_count - CW'(i_pop_cnt) + CW'(i_push_a) + CW'(i_push_b);
    end
  end

endmodule

// File: rtl/rename_alloc_ctrl.sv
// rtl/rename_alloc_ctrl.sv - rename tag allocator: init FSM, all-or-nothing grant, retire frees
module rename_alloc_ctrl #(
  parameter int NUM_PREGS = rename_alloc_ctrl_pkg::NUM_PREGS,
  parameter int NUM_AREGS = rename_alloc_ctrl_pkg::NUM_AREGS
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     alloc_req_a,
  input  logic                                     alloc_req_b,
  input  rename_alloc_ctrl_pkg::freeRegStruct      freeReg_a,
  input  rename_alloc_ctrl_pkg::freeRegStruct      freeReg_b,
  input  logic                                     flush_i,
  output logic [rename_alloc_ctrl_pkg::PREG_W-1:0] alloc_tag_a_o,
  output logic [rename_alloc_ctrl_pkg::PREG_W-1:0] alloc_tag_b_o,
  output logic                                     alloc_grant_o,
  output logic                                     stall_o,
  output logic                                     ready_o,
  output logic [$clog2(NUM_PREGS):0]               free_count_o,
  output logic                                     overflow_err_o
);

  localparam int PW = rename_alloc_ctrl_pkg::PREG_W;
  localparam int CW = $clog2(NUM_PREGS) + 1;
  localparam int IW = $clog2(NUM_AREGS);

  rename_alloc_ctrl_pkg::alloc_state_e r_state, w_state_nxt;
  logic [IW-1:0] r_init_ptr;
  logic          r_overflow;

  logic [1:0]    w_needed;
  logic [CW-1:0] w_count;
  logic [PW-1:0] w_rd_a, w_rd_b;
  logic          w_clear, w_grant, w_ovf_set;
  logic [1:0]    w_pop;
  logic          w_push_a, w_push_b;
  logic [PW-1:0] w_push_a_data, w_push_b_data;
  logic          w_fa_ok, w_fb_ok;

  assign w_needed = {1'b0, alloc_req_a} + {1'b0, alloc_req_b};
  assign w_fa_ok  = freeReg_a.valid && (freeReg_a.reg_addr != '0);
  assign w_fb_ok  = freeReg_b.valid && (freeReg_b.reg_addr != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= rename_alloc_ctrl_pkg::ST_INIT;
      r_init_ptr <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= (r_state == rename_alloc_ctrl_pkg::ST_INIT && !flush_i) ? r_init_ptr + IW'(1) : '0;
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clear       = 1'b0;
    w_grant       = 1'b0;
    w_pop         = 2'd0;
    w_push_a      = 1'b0;
    w_push_a_data = '0;
    w_push_b      = 1'b0;
    w_push_b_data = '0;
    w_ovf_set     = 1'b0;
    case (r_state)
      rename_alloc_ctrl_pkg::ST_INIT: begin
        if (flush_i) begin
          w_clear = 1'b1;
        end else begin
          w_push_a      = 1'b1;
          w_push_a_data = PW'(r_init_ptr) + PW'(NUM_AREGS);
          if (r_init_ptr == IW'(NUM_AREGS - 1)) w_state_nxt = rename_alloc_ctrl_pkg::ST_RUN;
        end
      end
      default: begin
        if (flush_i) begin
          w_clear     = 1'b1;
          w_state_nxt = rename_alloc_ctrl_pkg::ST_INIT;
        end else begin
          w_grant = (w_needed != 2'd0) && (w_count >= CW'(w_needed));
          w_pop   = w_grant ? w_needed : 2'd0;
          // Room check uses the pre-update count; same-cycle pops give no credit.
          w_push_a      = w_fa_ok && (w_count < CW'(NUM_PREGS));
          w_push_b      = w_fb_ok && ((w_count + CW'(w_push_a)) < CW'(NUM_PREGS));
          w_push_a_data = freeReg_a.reg_addr;
          w_push_b_data = freeReg_b.reg_addr;
          w_ovf_set     = (w_fa_ok && !w_push_a) || (w_fb_ok && !w_push_b);
        end
      end
    endcase
  end

  prf_free_fifo #(.DEPTH(NUM_PREGS), .W(PW)) u_free_fifo (
    .clk           (clk),
    .rst           (reset),
    .i_clear       (w_clear),
    .i_pop_cnt     (w_pop),
    .i_push_a      (w_push_a),
    .i_push_a_data (w_push_a_data),
    .i_push_b      (w_push_b),
    .i_push_b_data (w_push_b_data),
    .o_rd_a        (w_rd_a),
    .o_rd_b        (w_rd_b),
    .o_count       (w_count)
  );

  assign alloc_grant_o  = w_grant;
  assign stall_o        = (w_needed != 2'd0) && !w_grant;
  assign ready_o        = (r_state == rename_alloc_ctrl_pkg::ST_RUN);
  assign free_count_o   = w_count;
  assign overflow_err_o = r_overflow;
  // Slot B takes the head entry when slot A is idle.
  assign alloc_tag_a_o  = (w_grant && alloc_req_a) ? w_rd_a : '0;
  assign alloc_tag_b_o  = (w_grant && alloc_req_b) ? (alloc_req_a ? w_rd_b : w_rd_a) : '0;

  assert property (@(posedge clk) disable iff (reset) alloc_grant_o |-> (w_count >= CW'(w_needed)));
  assert property (@(posedge clk) disable iff (reset) w_count <= CW'(NUM_PREGS));
  assert property (@(posedge clk) disable iff (reset) alloc_grant_o |-> (r_state == rename_alloc_ctrl_pkg::ST_RUN));

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// tb/tb_rename_alloc_ctrl.sv - randomized and directed checks against a free-list queue model
module tb_rename_alloc_ctrl;
  import rename_alloc_ctrl_pkg::*;

  logic         clk;
  logic         reset;
  logic         alloc_req_a, alloc_req_b, flush_i;
  freeRegStruct freeReg_a, freeReg_b;
  logic [5:0]   alloc_tag_a_o, alloc_tag_b_o;
  logic         alloc_grant_o, stall_o, ready_o, overflow_err_o;
  logic [6:0]   free_count_o;

  int vectors = 0;
  int miscompares = 0;

  int q[$];
  bit m_run;
  bit m_ovf;

  rename_alloc_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .alloc_req_a    (alloc_req_a),
    .alloc_req_b    (alloc_req_b),
    .freeReg_a      (freeReg_a),
    .freeReg_b      (freeReg_b),
    .flush_i        (flush_i),
    .alloc_tag_a_o  (alloc_tag_a_o),
    .alloc_tag_b_o  (alloc_tag_b_o),
    .alloc_grant_o  (alloc_grant_o),
    .stall_o        (stall_o),
    .ready_o        (ready_o),
    .free_count_o   (free_count_o),
    .overflow_err_o (overflow_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rs, input bit ra, input bit rb,
                      input bit fav, input int faa, input bit fbv, input int fba, input bit fl);
    int needed, ea, eb, s0;
    bit g, oka, okb, acc_a, acc_b;
    @(negedge clk);
    reset              = rs;
    alloc_req_a        = ra;
    alloc_req_b        = rb;
    freeReg_a.valid    = fav;
    freeReg_a.reg_addr = 6'(faa);
    freeReg_b.valid    = fbv;
    freeReg_b.reg_addr = 6'(fba);
    flush_i            = fl;
    if (rs) begin
      q.delete();
      m_run = 0;
      m_ovf = 0;
    end
    #1;
    needed = int'(ra) + int'(rb);
    g  = m_run && !rs && !fl && needed != 0 && q.size() >= needed;
    ea = (g && ra) ? q[0] : 0;
    eb = (g && rb) ? q[ra ? 1 : 0] : 0;
    chk("grant", alloc_grant_o, g);
    chk("stall", stall_o, (needed != 0) && !g);
    chk("ready", ready_o, m_run);
    chk("count", free_count_o, q.size());
    chk("ovf", overflow_err_o, m_ovf);
    chk("tag_a", alloc_tag_a_o, ea);
    chk("tag_b", alloc_tag_b_o, eb);
    if (rs) return;
    if (!m_run) begin
      if (fl) q.delete();
      else begin
        q.push_back(NUM_AREGS + q.size());
        if (q.size() == NUM_AREGS) m_run = 1;
      end
    end else if (fl) begin
      q.delete();
      m_run = 0;
    end else begin
      s0    = q.size();
      oka   = fav && (faa % NUM_PREGS) != 0;
      okb   = fbv && (fba % NUM_PREGS) != 0;
      acc_a = oka && s0 < NUM_PREGS;
      acc_b = okb && (s0 + int'(acc_a)) < NUM_PREGS;
      if ((oka && !acc_a) || (okb && !acc_b)) m_ovf = 1;
      if (g) repeat (needed) void'(q.pop_front());
      if (acc_a) q.push_back(faa % NUM_PREGS);
      if (acc_b) q.push_back(fba % NUM_PREGS);
    end
  endtask

  task automatic rand_steps(input int n, input bit allow_flush);
    repeat (n)
      step(0, 1'($urandom), 1'($urandom),
           1'($urandom), int'($urandom_range(0, 63)),
           1'($urandom), int'($urandom_range(0, 63)),
           allow_flush && ($urandom_range(0, 63) == 0));
  endtask

  initial begin
    reset = 1'b1;
    alloc_req_a = 0; alloc_req_b = 0; flush_i = 0;
    freeReg_a = '0; freeReg_b = '0;
    step(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (32) step(0, 0, 1, 1, 7, 0, 0, 0);
    repeat (16) step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 40, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 41, 0, 0, 0);
    step(0, 1, 1, 1, 45, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 0, 0, 1, (i % 31) + 1, 1, (i % 31) + 33, 0);
    step(0, 0, 0, 1, 9, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) step(0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 1);
    repeat (32) step(0, 0, 0, 1, 3, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    rand_steps(400, 1);
    step(1, 1, 1, 1, 3, 0, 0, 0);
    rand_steps(40, 0);
    rand_steps(300, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
